// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end.
//   XLEN             : architectural register / address width
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one fetched instruction word together with its address
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO holding fetched {instr, pc} entries between the
// instruction memory response and decode.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : drop the head entry
//   flush       : discard every entry (takes priority over push/pop)
//   head        : current head entry (meaningful only when !empty)
//   occupancy   : number of valid entries
//   empty       : occupancy == 0
// ----------------------------------------------------------------------------
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (occupancy == '0);

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues in-order imem requests with a
// bounded number outstanding, buffers responses and hands them to decode over
// valid/ready. A redirect flushes the buffer and drops wrong-path responses.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds misalign_fault port;
// a misaligned redirect target raises a sticky fault and halts fetching).
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr          : request channel to instruction memory
//   imem_rsp_valid/data                : in-order response channel
//   redirect_valid/target              : taken branch/jump from the controller
//   instr_valid/ready                  : handshake to decode
//   instr, instr_pc, instr_pc_plus4    : buffer head word, its pc, pc + 4
//   misalign_fault                     : only with FETCH_MISALIGN_CHECK_EN
// ----------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH       = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misalign_fault
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [XLEN-1:0]  pc_queue [MAX_OUTSTANDING];
    logic [PQ_W-1:0]  pq_wr;
    logic [PQ_W-1:0]  pq_rd;
    logic [XLEN-1:0]  last_pc;
    logic [XLEN-1:0]  target_pc;
    logic [XLEN-1:0]  credit_used;
    logic             halted;
    logic             req_fire;
    logic             pop;
    logic             keep_rsp;
    logic             buf_empty;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
        return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    // Every redirect re-evaluates the fault, so an aligned redirect clears it.
    // The fault and the halt are the same condition, so one flop serves both.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_fault <= 1'b0;
        end else if (redirect_valid) begin
            misalign_fault <= (redirect_target[1:0] != 2'b00);
        end
    end

    assign halted    = misalign_fault;
    assign target_pc = redirect_target;
`else
    assign halted    = 1'b0;
    assign target_pc = redirect_target & ~32'd3;
`endif

    assign pop = instr_valid & instr_ready;

    // Credit check: every request in flight plus every buffered word must fit
    // in the buffer, so a response can always be accepted without stalling.
    always_comb begin
        credit_used    = 32'(outstanding) + 32'(occupancy) - 32'(pop);
        imem_req_valid = !reset && !redirect_valid && !halted
                         && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         && (credit_used < 32'(BUF_DEPTH));
    end

    assign req_fire      = imem_req_valid & imem_req_ready;
    assign imem_req_addr = fetch_pc;
    assign keep_rsp      = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign push_entry    = '{instr: imem_rsp_data, pc: pc_queue[pq_rd]};

    // PC, in-flight counters and the drop counter. Dropped responses still
    // retire their pc_queue slot so the queue stays in step with memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            last_pc     <= RESET_PC;
        end else begin
            if (redirect_valid) fetch_pc <= target_pc;
            else if (req_fire)  fetch_pc <= fetch_pc + 32'd4;

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if (redirect_valid)
                drop_cnt <= outstanding - OUT_W'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;

            if (req_fire)       pq_wr <= pq_next(pq_wr);
            if (imem_rsp_valid) pq_rd <= pq_next(pq_rd);

            if (instr_valid)    last_pc <= head.pc;
        end
    end

    // Addresses of in-flight requests, consumed in response order.
    always_ff @(posedge clk) begin
        if (req_fire && !reset) pc_queue[pq_wr] <= fetch_pc;
    end

    fetch_buffer #(
        .DEPTH      (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (keep_rsp),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .occupancy  (occupancy),
        .empty      (buf_empty)
    );

    // When idle, decode sees a NOP while the pc outputs hold their last value.
    assign instr_valid    = !buf_empty;
    assign instr          = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc       = instr_valid ? head.pc : last_pc;
    assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. A small in-order memory model
// with configurable latency returns ~addr as the instruction word, so each
// delivered word can be checked against its expected address.
// Honours FETCH_MISALIGN_CHECK_EN to exercise the misalignment fault.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int errors = 0;
    int checks = 0;
    int memLatency = 1;
    int memCycle = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    logic [31:0] gotPc[$];
    logic [31:0] gotInstr[$];
    logic [31:0] gotPlus4[$];
    logic [31:0] expPc[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault  (misalign_fault)
`endif
    );

    // Cycle counter for the memory model's due times.
    always @(posedge clk) memCycle <= memCycle + 1;

    // In-order memory: a request seen mid-cycle is accepted at the coming
    // edge and answered memLatency cycles later.
    always @(negedge clk) begin
        if (reset) begin
            memQ.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (memQ.size() > 0 && memQ[0].due <= memCycle) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~memQ[0].addr;
                void'(memQ.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            if (imem_req_valid && imem_req_ready)
                memQ.push_back('{addr: imem_req_addr, due: memCycle + memLatency});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // One cycle: drive inputs just after the edge, then log any delivery.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset           = rst;
        instr_ready     = rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        #1;
        if (!rst && instr_valid && instr_ready) begin
            gotPc.push_back(instr_pc);
            gotInstr.push_back(instr);
            gotPlus4.push_back(instr_pc_plus4);
        end
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, "_rst_instr_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_rst_instr"}, instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput({tag, "_rst_fault"}, 32'(misalign_fault), 32'd0);
`endif
        gotPc.delete();
        gotInstr.delete();
        gotPlus4.delete();
        expPc.delete();
    endtask

    task automatic compareDeliveries(input string tag);
        checkOutput({tag, "_enough"}, 32'(gotPc.size() >= expPc.size()), 32'd1);
        for (int i = 0; i < expPc.size(); i++) begin
            if (i < gotPc.size()) begin
                checkOutput($sformatf("%s_pc%0d", tag, i), gotPc[i], expPc[i]);
                checkOutput($sformatf("%s_instr%0d", tag, i), gotInstr[i], ~expPc[i]);
                checkOutput($sformatf("%s_plus4_%0d", tag, i), gotPlus4[i], expPc[i] + 32'd4);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;

        // Streaming with 1-cycle memory, then a 5-cycle decode stall.
        memLatency = 1;
        doReset("AB");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("A_req_valid_c1", 32'(imem_req_valid), 32'd1);
        checkOutput("A_req_addr_c1", imem_req_addr, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("A_req_addr_c2", imem_req_addr, 32'h4);
        checkOutput("A_instr_valid_c2", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("A_instr_valid_c3", 32'(instr_valid), 32'd1);
        for (int c = 4; c <= 6; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int c = 7; c <= 11; c++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("B_req_valid_stall", 32'(imem_req_valid), 32'd0);
        checkOutput("B_instr_valid_stall", 32'(instr_valid), 32'd1);
        checkOutput("B_head_pc_stall", instr_pc, 32'h10);
        for (int c = 12; c <= 20; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 13; i++) expPc.push_back(32'(4 * i));
        checkOutput("B_count", 32'(gotPc.size()), 32'd13);
        compareDeliveries("AB");

        // 3-cycle memory, redirect with two requests in flight.
        memLatency = 3;
        doReset("C");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput("C_req_valid_redirect", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("C_req_valid_full", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("C_req_valid_c5", 32'(imem_req_valid), 32'd1);
        checkOutput("C_req_addr_c5", imem_req_addr, 32'h100);
        for (int c = 6; c <= 20; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expPc = {32'h100, 32'h104, 32'h108};
        compareDeliveries("C");

        // Redirect coinciding with a pop and an arriving response.
        memLatency = 1;
        doReset("D");
        for (int c = 1; c <= 5; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        checkOutput("D_req_valid_redirect", 32'(imem_req_valid), 32'd0);
        checkOutput("D_pop_pc", instr_pc, 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("D_instr_valid_r1", 32'(instr_valid), 32'd0);
        checkOutput("D_instr_nop_r1", instr, 32'h0000_0013);
        checkOutput("D_hold_pc_r1", instr_pc, 32'hC);
        checkOutput("D_hold_plus4_r1", instr_pc_plus4, 32'h10);
        checkOutput("D_req_addr_r1", imem_req_addr, 32'h40);
        checkOutput("D_req_valid_r1", 32'(imem_req_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("D_instr_valid_r2", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("D_instr_valid_r3", 32'(instr_valid), 32'd1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expPc = {32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h48};
        compareDeliveries("D");

        // Address wrap at the top of the address space.
        doReset("E");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("E_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expPc = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        compareDeliveries("E");

        // Misaligned redirect target.
        doReset("F");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("F_fault_set", 32'(misalign_fault), 32'd1);
        checkOutput("F_req_halted_c2", 32'(imem_req_valid), 32'd0);
        for (int c = 3; c <= 6; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("F_req_halted_c%0d", c), 32'(imem_req_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("F_fault_clear", 32'(misalign_fault), 32'd0);
        checkOutput("F_req_resume", 32'(imem_req_valid), 32'd1);
        checkOutput("F_req_addr", imem_req_addr, 32'h200);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expPc = {32'h200, 32'h204};
`else
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("F_req_addr_aligned", imem_req_addr, 32'h100);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expPc = {32'h100, 32'h104};
`endif
        compareDeliveries("F");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of decode and the controller. Owns the program counter and issues in-order requests to instruction memory, tolerating variable response latency. Buffers returned words and hands `instr`/`pc`/`pc+4` to decode over a valid/ready handshake. Consumes the controller's branch/jump redirect (`PCSrc` plus target) and discards wrong-path fetches.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `BUF_DEPTH`, default 2: fetch buffer entries (≥2).
- `MAX_OUTSTANDING`, default 2: accepted-but-unanswered imem requests (≥1).

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response word valid, in request order.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: taken branch/jump (controller `PCSrc`).
- `redirect_target` in 32: new PC.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode accepts.
- `instr` out 32, `instr_pc` out 32, `instr_pc_plus4` out 32: instruction, its address, address+4.
- `misalign_fault` out 1: only with `FETCH_MISALIGN_CHECK_EN`.

## Operation

- `fetch_pc`: next address to request. It advances by 4 on each request handshake (`imem_req_valid & imem_req_ready`).
- Issue condition: `!redirect_valid && !halted && outstanding < MAX_OUTSTANDING && outstanding + occupancy − pop < BUF_DEPTH`, where `pop = instr_valid & instr_ready`. This credit rule guarantees every response has a buffer slot.
- `imem_req_valid` may deassert without a handshake. The imem interface does not require request stickiness.
- Response handling:
  - `drop_cnt == 0`: push `{data, pc}` into the buffer. The pc comes from an internal in-flight pc queue of depth `MAX_OUTSTANDING`.
  - `drop_cnt > 0`: discard the word and decrement `drop_cnt`.
- Redirect cycle:
  - Buffer flushed; `instr_valid` is 0 from the next cycle.
  - `fetch_pc <= redirect_target`.
  - `drop_cnt <= outstanding − (rsp arriving this cycle ? 1 : 0)`, and any response arriving in that cycle is discarded.
  - No request is issued in the redirect cycle.
- Redirect coinciding with pop: the pop completes for decode, and the entry behind it is flushed.
- `outstanding` counts +1 on request handshake and −1 on every response, whether kept or dropped.
- Address arithmetic is modulo 2^32. `fetch_pc` wraps from `FFFF_FFFC` to `0000_0000` with no special handling.
- Outputs show the buffer head. When `instr_valid` = 0, `instr` = `32'h0000_0013` (NOP), and `instr_pc`/`instr_pc_plus4` hold their last values.

## Timing

- All outputs are registered or derived from registers, except `imem_req_valid`, which is combinational on `redirect_valid`, `instr_ready` and the internal state.
- Reset values:
  - `fetch_pc = RESET_PC`
  - `outstanding`, `drop_cnt`, `occupancy` = 0
  - `instr_valid = 0`, `imem_req_valid = 0`, `misalign_fault = 0`
- Reset mid-operation discards all in-flight state. Responses to pre-reset requests are not expected; the memory is reset by the same `reset`.
- First request is in the first cycle after `reset` deasserts.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1), `instr_valid` in cycle N+k+1.
- With k=1 and `instr_ready` held high, throughput is 1 instr/cycle in steady state.
- First post-redirect request is issued the cycle after `redirect_valid`. A kept instruction reaches decode no earlier than redirect+3.

## Configuration

- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_target[1:0] != 0` does the following:
  - sets `misalign_fault`, sticky, registered the cycle after the redirect;
  - flushes the buffer as normal;
  - sets `halted`, so no further requests are issued.
- Once set, the fault clears on reset, or on a later redirect with an aligned target.
- Undefined: `misalign_fault` port absent, `redirect_target[1:0]` forced to 0, no halt.

## Structure

- Shared package `riscv_pkg`: `XLEN = 32`, `NOP_INSTR = 32'h0000_0013`, default `RESET_PC`, and the packed typedef `fetch_entry_t {instr, pc}`.
- Sub-module `fetch_buffer`: synchronous FIFO of `fetch_entry_t`, `BUF_DEPTH` entries, with push, pop, flush and occupancy output.
- Pc queue, counters and issue logic live in `fetch_unit`.

## Test plan

- Reset, 1-cycle memory, `instr_ready`=1: requests at 0,4,8,…; `instr_valid` from cycle 3 with `instr_pc` 0,4,8 on consecutive cycles; `instr_pc_plus4` = pc+4.
- `instr_ready`=0 for 5 cycles: at most `BUF_DEPTH` words held, `imem_req_valid` drops, no word lost or duplicated when ready returns.
- 3-cycle memory latency, then redirect to `0x100` with 2 requests outstanding: the 2 late responses are dropped, and the next delivered `instr_pc` = `0x100`.
- Redirect in the same cycle as a response and a pop: popped word delivered once, arriving word dropped, `drop_cnt` correct, next `instr_pc` = target.
- `fetch_pc` = `FFFF_FFF8`: delivers `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to `0x102` gives `misalign_fault`=1 the next cycle, no further requests; redirect to `0x200` clears it and fetch resumes at `0x200`.
